fp_wb_arbiter: RTL
==================

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of write-back requesters (0=FADD, 1=FMUL, 2=FDIV).
REQ-002 Parameter DATA_W, default 32, write-back data width.
REQ-003 Parameter ADDR_W, default 5, FP register index width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 stall  in  1  pipeline hold; no grant while high.
REQ-008 req_valid  in  N_REQ  per-requester write-back valid.
REQ-009 req_addr  in  N_REQ x ADDR_W  per-requester destination register.
REQ-010 req_data  in  N_REQ x DATA_W  per-requester result.
REQ-011 req_ready  out  N_REQ  one-hot-or-zero grant; handshake when valid & ready.
REQ-012 wb_we  out  1  register-file write enable.
REQ-013 wb_addr  out  ADDR_W  register-file write index.
REQ-014 wb_data  out  DATA_W  register-file write data.
REQ-015 pending  out  1  high when any req_valid is high and not granted this cycle.

Function
REQ-016 At most one req_ready bit SHALL be high per cycle.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr, stall, rst; requesters SHALL NOT make req_valid depend on req_ready.
REQ-018 Arbitration: round-robin; search starts at rr_ptr, ascending index, wrap N_REQ-1 -> 0; first valid requester wins.
REQ-019 After a grant to index i, rr_ptr SHALL become (i+1) mod N_REQ on the next edge; with no grant rr_ptr SHALL hold.
REQ-020 stall=1: all req_ready=0, rr_ptr holds, wb_we=0 on next edge.
REQ-021 Latency: handshake in cycle N -> wb_we=1 with granted addr/data in cycle N+1, exactly one cycle.
REQ-022 Cycle without handshake -> wb_we=0 next cycle; wb_addr/wb_data hold last written values.
REQ-023 Requester SHALL hold req_valid/addr/data stable until handshake; block accepts back-to-back grants every cycle (throughput 1 write/cycle).
REQ-024 Same destination from two requesters: both written on successive cycles in round-robin order; no merging or dropping.
REQ-025 Single requester continuously valid SHALL be granted every cycle.
REQ-026 Starvation bound: a continuously valid requester SHALL be granted within N_REQ cycles of stall-free operation.

Reset
REQ-027 While rst=1: req_ready=0, pending=0 regardless of inputs.
REQ-028 On edge with rst=1: wb_we=0, wb_addr=0, wb_data=0, rr_ptr=0.
REQ-029 Reset mid-operation: ungranted requests are not lost by the block; requesters keep valid and are arbitrated from rr_ptr=0 after release.
REQ-030 No write SHALL occur in the cycle after a cycle with rst=1.

Structure
REQ-031 Package fp_wb_pkg SHALL hold N_REQ, DATA_W, ADDR_W defaults and the requester index enum (REQ_FADD, REQ_FMUL, REQ_FDIV).
REQ-032 Sub-module rr_pick (valid vector + pointer -> one-hot grant + granted index) SHALL be the only child; output registers and rr_ptr live in fp_wb_arbiter.

Verification
REQ-033 Reset: rst=1 with all valid -> req_ready=000, next cycle wb_we=0, wb_addr=0, wb_data=0.
REQ-034 Single: valid=001, addr=5, data=0x3F800000 -> ready=001 same cycle, next cycle wb_we=1, wb_addr=5, wb_data=0x3F800000.
REQ-035 Fairness: valid=111 held, rr_ptr=0 -> grant order 0,1,2,0 over four cycles, wb_we=1 every cycle.
REQ-036 Stall: valid=110, stall=1 for 3 cycles -> ready=000, wb_we=0, rr_ptr unchanged; stall=0 -> grant 1 then 2.
REQ-037 Collision: req0 addr=7 data=0x40000000, req1 addr=7 data=0x40400000, rr_ptr=0 -> writes f7=0x40000000 then f7=0x40400000.
REQ-038 Reset mid-burst: valid=111, rst after grant 0 -> next arbitration after release grants 0 (rr_ptr=0), no write in reset-following cycle.

Source files
------------

// File: rtl/fp_wb_pkg.sv
// ---------------------------------------------------------------------------
// fp_wb_pkg
// Shared definitions for the FP write-back arbiter:
//   - default requester count, data width and register index width
//   - requester index enumeration (which FP unit sits on which port)
//   - helper to size the round-robin pointer
// ---------------------------------------------------------------------------
package fp_wb_pkg;

  localparam int FP_WB_N_REQ  = 3;
  localparam int FP_WB_DATA_W = 32;
  localparam int FP_WB_ADDR_W = 5;

  // Requester port assignment.
  typedef enum logic [1:0] {
    REQ_FADD = 2'd0,
    REQ_FMUL = 2'd1,
    REQ_FDIV = 2'd2
  } fp_wb_req_e;

  // Pointer width; a single requester still gets a 1-bit pointer so that
  // no zero-width vectors appear.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_wb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Starting at ptr_i and walking
// upward with wrap from N-1 to 0, the first set bit of valid_i wins.
// Ports:
//   valid_i [N]      request vector
//   ptr_i   [PTR_W]  index with highest priority this cycle (must be < N)
//   grant_o [N]      one-hot grant, all-zero when valid_i is zero
//   idx_o   [PTR_W]  index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] idx_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i + k is below 2N, so one conditional subtract is a full modulo.
      sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N)) begin
        sum = sum - (PTR_W + 1)'(N);
      end
      cand = sum[PTR_W-1:0];
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fp_wb_arbiter
// Round-robin arbiter that lets the FP execution units (FADD, FMUL, FDIV)
// share one register-file write port. One write per cycle, registered.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   stall       pipeline hold: no grant while high
//   req_valid   per-requester write-back valid
//   req_addr    per-requester destination register index
//   req_data    per-requester result
//   req_ready   one-hot-or-zero grant
//   wb_we       register-file write enable (one cycle after the handshake)
//   wb_addr     register-file write index (holds last written value)
//   wb_data     register-file write data (holds last written value)
//   pending     some valid requester was not granted this cycle
//
// Handshake: a requester raises req_valid and holds req_valid/addr/data
// stable until it sees req_ready high in the same cycle; valid & ready is
// the transfer. req_ready is combinational from req_valid, the round-robin
// pointer, stall and rst, so req_valid must never be derived from
// req_ready.
// ---------------------------------------------------------------------------
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int N_REQ  = FP_WB_N_REQ,
  parameter int DATA_W = FP_WB_DATA_W,
  parameter int ADDR_W = FP_WB_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          wb_we,
  output logic [ADDR_W-1:0]             wb_addr,
  output logic [DATA_W-1:0]             wb_data,
  output logic                          pending
);

  localparam int PTR_W = ptr_width(N_REQ);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              hs;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    // Reset and stall both mask the grant; the picker itself is unaware.
    req_ready = (rst || stall) ? '0 : pick_grant;
    hs        = |req_ready;
    pending   = !rst && (|(req_valid & ~req_ready));

    rr_ptr_d  = rr_ptr_q;
    wb_we_d   = hs;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (hs) begin
      rr_ptr_d  = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      wb_addr_d = req_addr[pick_idx];
      wb_data_d = req_data[pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule
